// File: rtl/vx_fetch_arb_pkg.sv
// vx_fetch_arbiter shared types: run/drain state encoding and credit width.
package vx_fetch_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    localparam int CREDIT_W = 3;

endpackage

// File: rtl/vx_fetch_arbiter_if.sv
// Fetch request (valid/ready) and icache credit-return bundle.
interface vx_fetch_arbiter_if #(
    parameter int WID_W    = 2,
    parameter int PC_WIDTH = 32
);
    logic                req_valid;
    logic [WID_W-1:0]    req_wid;
    logic [PC_WIDTH-1:0] req_pc;
    logic                req_ready;
    logic                rsp_valid;
    logic [WID_W-1:0]    rsp_wid;

    modport master (
        output req_valid, req_wid, req_pc,
        input  req_ready, rsp_valid, rsp_wid
    );

    modport slave (
        input  req_valid, req_wid, req_pc,
        output req_ready, rsp_valid, rsp_wid
    );
endinterface

// File: rtl/vx_rr_picker.sv
// Combinational round-robin find-first starting at ptr_i, wrapping at N-1.
module vx_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         valid_o
);
    // Scan from the far end so the nearest hit to ptr_i wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[ptr_i + W'(k)]) begin
                gnt_o   = ptr_i + W'(k);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vx_fetch_arbiter.sv
// Round-robin warp fetch scheduler with per-warp credits and run/drain FSM.
// Optional perf counters enabled by defining VX_FETCH_ARB_PERF_EN.
module vx_fetch_arbiter
    import vx_fetch_arb_pkg::*;
#(
    parameter int NUM_WARPS    = 4,
    parameter int PC_WIDTH     = 32,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic [NUM_WARPS-1:0]          warp_active,
    input  logic [NUM_WARPS-1:0]          warp_stalled,
    input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
    vx_fetch_arbiter_if.master            fif,
    output logic                          busy,
    output logic [31:0]                   perf_issued,
    output logic [31:0]                   perf_stall
);
    localparam int WID_W = $clog2(NUM_WARPS);

    fetch_state_e        state_q, state_d;
    logic                req_valid_q, req_valid_d;
    logic [WID_W-1:0]    req_wid_q, req_wid_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [WID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_W-1:0] credit_q [NUM_WARPS];
    logic [CREDIT_W-1:0] credit_d [NUM_WARPS];

    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] inc, dec;
    logic [WID_W-1:0]     sel;
    logic                 sel_valid;
    logic                 load, accept, credits_zero;

    always_comb begin
        eligible     = '0;
        credits_zero = 1'b1;
        for (int i = 0; i < NUM_WARPS; i++) begin
            eligible[i] = warp_active[i] && !warp_stalled[i] &&
                          (credit_q[i] < CREDIT_W'(MAX_INFLIGHT));
            if (credit_q[i] != '0) credits_zero = 1'b0;
        end
    end

    vx_rr_picker #(.N(NUM_WARPS), .W(WID_W)) u_picker (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (sel),
        .valid_o (sel_valid)
    );

    assign accept = req_valid_q && fif.req_ready;
    assign load   = (state_q == ST_RUN) &&
                    (!req_valid_q || fif.req_ready) && sel_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (stop) state_d = ST_DRAIN;
            ST_DRAIN: if (!req_valid_q && credits_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_wid_d   = req_wid_q;
        req_pc_d    = req_pc_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            req_valid_d = 1'b1;
            req_wid_d   = sel;
            req_pc_d    = warp_pc[int'(sel)*PC_WIDTH +: PC_WIDTH];
            rr_ptr_d    = sel + WID_W'(1);
        end else if (accept) begin
            req_valid_d = 1'b0;
        end
    end

    // Issue and return on the same warp cancel; stray returns saturate at 0.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            inc[i]      = load && (sel == WID_W'(i));
            dec[i]      = fif.rsp_valid && (fif.rsp_wid == WID_W'(i));
            credit_d[i] = credit_q[i];
            if (inc[i] && !dec[i])
                credit_d[i] = credit_q[i] + CREDIT_W'(1);
            else if (dec[i] && !inc[i] && credit_q[i] != '0)
                credit_d[i] = credit_q[i] - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_wid_q   <= '0;
            req_pc_q    <= '0;
            rr_ptr_q    <= '0;
            for (int i = 0; i < NUM_WARPS; i++) credit_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_wid_q   <= req_wid_d;
            req_pc_q    <= req_pc_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int i = 0; i < NUM_WARPS; i++) credit_q[i] <= credit_d[i];
        end
    end

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (reset)
        !(fif.rsp_valid && credit_q[fif.rsp_wid] == '0));

    assign fif.req_valid = req_valid_q;
    assign fif.req_wid   = req_wid_q;
    assign fif.req_pc    = req_pc_q;
    assign busy          = (state_q != ST_IDLE) || req_valid_q;

`ifdef VX_FETCH_ARB_PERF_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (accept) issued_q <= issued_q + 32'd1;
            if (req_valid_q && !fif.req_ready) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule
